// File: rtl/reflock_led_pkg.sv
// reflock_led_pkg: shared LED mode encodings, sequencer states and default timebase constants
package reflock_led_pkg;

   typedef enum logic [1:0] {
      LED_OFF  = 2'b00,
      LED_ON   = 2'b01,
      LED_SLOW = 2'b10,
      LED_FAST = 2'b11
   } led_mode_e;

   typedef enum logic [1:0] {SELFTEST, RUN, ALARM} state_e;

   localparam int DEF_TICK_DIV       = 100000;
   localparam int DEF_SLOW_HALF      = 50;
   localparam int DEF_FAST_HALF      = 10;
   localparam int DEF_PULSE_TICKS    = 5;
   localparam int DEF_SELFTEST_TICKS = 100;

   function automatic logic led_pattern(input logic [1:0] mode, input logic slow, input logic fast);
      return mode == LED_ON ? 1'b1 : mode == LED_SLOW ? slow : mode == LED_FAST ? fast : 1'b0;
   endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler: divides clock by DIV and emits a one-cycle tick on the last count
module led_tick_prescaler #(
   parameter int DIV = 100000
)(
   input  logic clock,
   input  logic reset_n,
   output logic tick
);
   localparam int W = DIV > 1 ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = cnt == W'(DIV - 1);

   // free-running 0..DIV-1 counter
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/reflock_led_sequencer.sv
// reflock_led_sequencer: self-test, pattern, pulse-stretch and alarm sequencing of LED1/LED2; LED_PWM_DIM_EN adds dim PWM
module reflock_led_sequencer
   import reflock_led_pkg::*;
#(
   parameter int TICK_DIV       = DEF_TICK_DIV,
   parameter int SLOW_HALF      = DEF_SLOW_HALF,
   parameter int FAST_HALF      = DEF_FAST_HALF,
   parameter int PULSE_TICKS    = DEF_PULSE_TICKS,
   parameter int SELFTEST_TICKS = DEF_SELFTEST_TICKS
)(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] led1_mode,
   input  logic [1:0] led2_mode,
   input  logic       led1_pulse,
   input  logic       led2_pulse,
   input  logic       alarm,
`ifdef LED_PWM_DIM_EN
   input  logic [3:0] dim,
`endif
   output logic       selftest_busy,
   output logic       LED1,
   output logic       LED2
);
   localparam int SW = SLOW_HALF > 1 ? $clog2(SLOW_HALF) : 1;
   localparam int FW = FAST_HALF > 1 ? $clog2(FAST_HALF) : 1;
   localparam int PW = $clog2(PULSE_TICKS + 1);
   localparam int TW = SELFTEST_TICKS > 1 ? $clog2(SELFTEST_TICKS) : 1;

   logic          tick, slow_ph, fast_ph, slow_last, fast_last, st_last;
   logic          pa1, pa2, on, led1_d, led2_d;
   logic [SW-1:0] slow_cnt;
   logic [FW-1:0] fast_cnt;
   logic [PW-1:0] pc1, pc2;
   logic [TW-1:0] st_cnt;
   state_e        state, nxt;

   led_tick_prescaler #(.DIV(TICK_DIV)) u_pre (.clock(clock), .reset_n(reset_n), .tick(tick));

   assign slow_last     = slow_cnt == SW'(SLOW_HALF - 1);
   assign fast_last     = fast_cnt == FW'(FAST_HALF - 1);
   assign st_last       = st_cnt == TW'(SELFTEST_TICKS - 1);
   assign pa1           = pc1 != '0;
   assign pa2           = pc2 != '0;
   assign selftest_busy = state == SELFTEST;

   // slow/fast blink phases, free-running in every state
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         slow_cnt <= '0;
         fast_cnt <= '0;
         slow_ph  <= 1'b0;
         fast_ph  <= 1'b0;
      end else if (tick) begin
         slow_cnt <= slow_last ? '0 : slow_cnt + 1'b1;
         fast_cnt <= fast_last ? '0 : fast_cnt + 1'b1;
         slow_ph  <= slow_ph ^ slow_last;
         fast_ph  <= fast_ph ^ fast_last;
      end

   // pulse stretchers: a strobe reloads, ticks count down to zero
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         pc1 <= '0;
         pc2 <= '0;
      end else begin
         pc1 <= led1_pulse ? PW'(PULSE_TICKS) : (tick && pa1) ? pc1 - 1'b1 : pc1;
         pc2 <= led2_pulse ? PW'(PULSE_TICKS) : (tick && pa2) ? pc2 - 1'b1 : pc2;
      end

   // self-test duration in ticks
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) st_cnt <= '0;
      else if (tick && state == SELFTEST) st_cnt <= st_last ? '0 : st_cnt + 1'b1;

   // sequencer state register
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= SELFTEST;
      else state <= nxt;

   // next state and LED drive for the current state
   always_comb begin
      nxt    = state;
      led1_d = 1'b1;
      led2_d = 1'b1;
      case (state)
         SELFTEST: if (tick && st_last) nxt = alarm ? ALARM : RUN;
         RUN: begin
            nxt    = alarm ? ALARM : RUN;
            led1_d = pa1 | led_pattern(led1_mode, slow_ph, fast_ph);
            led2_d = pa2 | led_pattern(led2_mode, slow_ph, fast_ph);
         end
         ALARM: begin
            nxt    = alarm ? ALARM : RUN;
            led1_d = fast_ph;
            led2_d = ~fast_ph;
         end
         default: nxt = SELFTEST;
      endcase
   end

`ifdef LED_PWM_DIM_EN
   logic [3:0] pwm_cnt;

   // dimming PWM, duty (dim+1)/16
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) pwm_cnt <= '0;
      else pwm_cnt <= pwm_cnt + 1'b1;

   assign on = pwm_cnt <= dim;
`else
   assign on = 1'b1;
`endif

   // registered LED outputs
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         LED1 <= 1'b0;
         LED2 <= 1'b0;
      end else begin
         LED1 <= led1_d & on;
         LED2 <= led2_d & on;
      end

endmodule
